dcp_mem_ctrl: RTL and testbench
===============================

Name: dcp_mem_ctrl

Overview:
- Generalised memory-access child of the serial debug control panel (DCP); replaces the fixed single-memory D/I dump children.
- Serves dump and write commands over a parametrised number of CPU memories.
- Talks to the shared SCAN (receive) and PRINT (transmit) engines through the existing req/ack handshakes.
- Adds two things the old children lacked: a multi-word dump length, and memory writes with per-channel write enables.

Parameters:
- NCH, 2: number of memory channels (0 = data memory, 1 = instruction memory, ...).
- AW, 8: memory word-address width.
- DW, 32: memory data width, 1..32.
- DUMP_LEN, 8: words printed per dump command, at least 1.
- RD_LAT, 1: memory read latency in clk cycles, 0..3.

Ports:
- clk  in  1  system clock
- rstn  in  1  synchronous active-low reset
- start  in  1  level; high while the parent has selected this block (parent sel_mode match)
- wr_mode  in  1  sampled at start rise; 0 = dump, 1 = write
- ch_sel  in  $clog2(NCH)  channel, sampled at start rise
- finish  out  1  command complete
- req_rx  out  1  SCAN request
- type_rx  out  1  0 = one char, 1 = hex word
- ack_rx  in  1  SCAN one-cycle done pulse
- flag_rx  in  1  with ack_rx: no number given (bare newline)
- din_rx  in  32  SCAN result
- req_tx  out  1  PRINT request
- type_tx  out  1  0 = char dout_tx[7:0], 1 = 8-digit hex word
- ack_tx  in  1  PRINT one-cycle done pulse
- dout_tx  out  32  PRINT data
- addr  out  AW  memory word address, shared by all channels
- din  out  DW  write data
- we  out  NCH  one-hot write enable
- dout_mem  in  NCH*DW  packed read data; channel k at [k*DW +: DW]

Behaviour:
- Clock and reset: one clock, clk. rstn is synchronous and active-low, sampled on the rising edge of clk.
- Reset values: state IDLE; all outputs 0; last-address register per channel 0.
- Handshakes:
  - req_rx/req_tx are driven high and held, with type and data stable, until the matching ack pulse.
  - Req drops in the cycle after ack.
  - Never more than one req high at a time.
- State machine:
  - IDLE: on start rise, latch wr_mode and ch_sel, go to GET_A.
  - GET_A: request a hex word.
    - flag_rx=0: addr = din_rx[AW-1:0]; upper bits are ignored.
    - flag_rx=1 in dump mode: addr = last_addr[ch].
    - flag_rx=1 in write mode: print "?" then go to DONE.
    - Dump goes to RD; write goes to GET_D.
  - GET_D: request a hex word.
    - flag_rx=1: print "?" then DONE, no write.
    - Otherwise din = din_rx[DW-1:0], then go to WR.
  - WR: we[ch]=1 for exactly one cycle, then DONE.
  - RD: wait RD_LAT cycles; latch dout_mem[ch], zero-extended to 32 bits.
  - PR_A: print addr as a hex word (zero-extended).
  - PR_S: print char ':' (8'h3A).
  - PR_D: print data as a hex word.
  - PR_N: print 8'h0A.
    - If fewer than DUMP_LEN words are printed, addr++ (mod 2^AW, wraps 2^AW-1 -> 0) and return to RD.
    - Otherwise last_addr[ch] = addr+1 (wrapped) and go to DONE.
- DONE: finish=1 held while start=1; when start falls, finish drops next cycle and the block returns to IDLE.
- start falling in any non-IDLE state is an abort:
  - Next cycle: IDLE with all outputs 0.
  - last_addr is not updated and no write occurs.
- Other outputs:
  - addr is held stable from RD entry through latching; it is 0 in IDLE.
  - Invalid ch_sel (>= NCH) prints "?" then DONE.
- A reset mid-operation has the same effect as the reset values above.

Optional Feature:
- Macro: DCP_MEM_READBACK_EN.
- Defined: after WR, the block performs RD on the same address, then PR_A/PR_S/PR_D/PR_N once. The operator sees the stored value, which catches read-only or missing memories.
- Undefined: WR goes directly to DONE; nothing is printed on a successful write.

Decomposition:
- Shared package dcp_pkg:
  - State encoding enum.
  - Char constants CH_COLON=8'h3A, CH_NL=8'h0A, CH_Q=8'h3F.
  - TX/RX type constants TY_CHAR=0, TY_HEX=1.
  - Command codes CMD_D/CMD_I/CMD_E, reused by the parent.
- One natural sub-module: dcp_tx_seq, a small PRINT sequencer taking a {type,data} item and returning done. It is shared by the A/S/D/N/"?" print states.

Test Plan:
- Dump, ch0, RX "10": 8 lines "00000010:<mem[0x10]>" ... "00000017:<mem[0x17]>"; then finish=1; last_addr[0]=0x18.
- Dump, ch0, RX bare newline (flag_rx=1) right after the previous case: dump starts at 0x18; also check 0xFC wraps 0xFF -> 0x00 (AW=8).
- Write, ch1, RX "20" then "DEADBEEF": we=2'b10 for exactly one cycle, addr=0x20, din=0xDEADBEEF; we[0] never high. With READBACK_EN: prints "00000020:DEADBEEF".
- Write, flag_rx=1 on data: prints "?", we stays 0, finish=1.
- Abort: drop start while req_tx is high in PR_D: next cycle req_tx=0, all outputs 0, state IDLE, last_addr unchanged; a new start gives a clean dump.
- RD_LAT=2 and ack_tx delayed by 50 cycles: data latched exactly 2 cycles after RD entry; dout_tx stays stable until ack_tx.

Source files
------------

// File: rtl/dcp_pkg.sv
// Shared definitions for the DCP children: state encoding, print characters,
// RX/TX item types and the command codes the parent decodes.
package dcp_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_GET_A,
    S_GET_D,
    S_WR,
    S_RD,
    S_PR_A,
    S_PR_S,
    S_PR_D,
    S_PR_N,
    S_PR_Q,
    S_DONE
  } state_e;

  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_NL    = 8'h0A;
  localparam logic [7:0] CH_Q     = 8'h3F;

  localparam logic TY_CHAR = 1'b0;
  localparam logic TY_HEX  = 1'b1;

  localparam logic [7:0] CMD_D = 8'h44;
  localparam logic [7:0] CMD_I = 8'h49;
  localparam logic [7:0] CMD_E = 8'h45;

  typedef struct packed {
    logic        ty;
    logic [31:0] data;
  } tx_item_t;

endpackage

// File: rtl/dcp_tx_seq.sv
// PRINT sequencer: latches one {type,data} item, holds req until ack and
// reports completion in the ack cycle.
module dcp_tx_seq
  import dcp_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        abort_i,
  input  logic        go_i,
  input  tx_item_t    item_i,
  input  logic        ack_tx_i,
  output logic        done_o,
  output logic        req_tx_o,
  output logic        type_tx_o,
  output logic [31:0] dout_tx_o
);

  logic     req_q;
  tx_item_t item_q;

  always_ff @(posedge clk) begin
    if (!rstn || abort_i || (req_q && ack_tx_i)) begin
      req_q  <= 1'b0;
      item_q <= '0;
    end else if (go_i && !req_q) begin
      req_q  <= 1'b1;
      item_q <= item_i;
    end
  end

  assign done_o    = req_q & ack_tx_i;
  assign req_tx_o  = req_q;
  assign type_tx_o = item_q.ty;
  assign dout_tx_o = item_q.data;

endmodule

// File: rtl/dcp_mem_ctrl.sv
// DCP memory-access child: multi-word dump and single-word write over NCH
// memories. Define DCP_MEM_READBACK_EN to print the stored word after a write.
module dcp_mem_ctrl
  import dcp_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int AW       = 8,
  parameter int DW       = 32,
  parameter int DUMP_LEN = 8,
  parameter int RD_LAT   = 1,
  parameter int CW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              wr_mode,
  input  logic [CW-1:0]     ch_sel,
  output logic              finish,
  output logic              req_rx,
  output logic              type_rx,
  input  logic              ack_rx,
  input  logic              flag_rx,
  input  logic [31:0]       din_rx,
  output logic              req_tx,
  output logic              type_tx,
  input  logic              ack_tx,
  output logic [31:0]       dout_tx,
  output logic [AW-1:0]     addr,
  output logic [DW-1:0]     din,
  output logic [NCH-1:0]    we,
  input  logic [NCH*DW-1:0] dout_mem
);

  localparam logic [31:0] CNT_LAST = 32'(DUMP_LEN - 1);

  state_e        state_q, state_d;
  logic          start_q;
  logic          wr_q, wr_d;
  logic [CW-1:0] ch_q, ch_d;
  logic [AW-1:0] addr_q, addr_d, addr_inc;
  logic [DW-1:0] din_q, din_d, rd_raw;
  logic [31:0]   data_q, data_d, addr_ext, rd_ext, cnt_q, cnt_d;
  logic [1:0]    lat_q, lat_d;
  logic          req_rx_q, req_rx_d, rx_ack;
  logic [AW-1:0] last_q [NCH];
  logic          last_we, tx_go, tx_abort, tx_done;
  tx_item_t      tx_item;
  logic          unused_rx;

  assign unused_rx = ^din_rx;
  assign rx_ack    = ack_rx & req_rx_q;
  assign addr_inc  = addr_q + 1'b1;

  always_comb begin
    rd_raw = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (ch_q == CW'(k)) rd_raw = dout_mem[k*DW +: DW];
    end
    rd_ext           = '0;
    rd_ext[DW-1:0]   = rd_raw;
    addr_ext         = '0;
    addr_ext[AW-1:0] = addr_q;
  end

  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    ch_d     = ch_q;
    addr_d   = addr_q;
    din_d    = din_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    lat_d    = lat_q;
    req_rx_d = 1'b0;
    last_we  = 1'b0;
    tx_go    = 1'b0;
    tx_abort = 1'b0;
    tx_item  = '0;
    unique case (state_q)
      S_IDLE: if (start && !start_q) begin
        wr_d    = wr_mode;
        ch_d    = ch_sel;
        cnt_d   = '0;
        state_d = (32'(ch_sel) >= NCH) ? S_PR_Q : S_GET_A;
      end
      S_GET_A, S_GET_D: begin
        req_rx_d = ~rx_ack;
        if (rx_ack) begin
          if (state_q == S_GET_A) begin
            if (!flag_rx) begin
              addr_d  = din_rx[AW-1:0];
              state_d = wr_q ? S_GET_D : S_RD;
            end else if (wr_q) begin
              state_d = S_PR_Q;
            end else begin
              addr_d  = last_q[ch_q];
              state_d = S_RD;
            end
          end else if (flag_rx) begin
            state_d = S_PR_Q;
          end else begin
            din_d   = din_rx[DW-1:0];
            state_d = S_WR;
          end
        end
      end
`ifdef DCP_MEM_READBACK_EN
      S_WR: state_d = S_RD;
`else
      S_WR: state_d = S_DONE;
`endif
      S_RD: begin
        if (lat_q == 2'(RD_LAT)) begin
          data_d  = rd_ext;
          lat_d   = '0;
          state_d = S_PR_A;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      S_PR_A: begin
        tx_go   = 1'b1;
        tx_item = {TY_HEX, addr_ext};
        if (tx_done) state_d = S_PR_S;
      end
      S_PR_S: begin
        tx_go   = 1'b1;
        tx_item = {TY_CHAR, 24'h0, CH_COLON};
        if (tx_done) state_d = S_PR_D;
      end
      S_PR_D: begin
        tx_go   = 1'b1;
        tx_item = {TY_HEX, data_q};
        if (tx_done) state_d = S_PR_N;
      end
      S_PR_N: begin
        tx_go   = 1'b1;
        tx_item = {TY_CHAR, 24'h0, CH_NL};
        if (tx_done) begin
          // readback after a write prints a single line and leaves last_addr alone
          if (wr_q) begin
            state_d = S_DONE;
          end else if (cnt_q < CNT_LAST) begin
            cnt_d   = cnt_q + 32'd1;
            addr_d  = addr_inc;
            state_d = S_RD;
          end else begin
            last_we = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_PR_Q: begin
        tx_go   = 1'b1;
        tx_item = {TY_CHAR, 24'h0, CH_Q};
        if (tx_done) state_d = S_DONE;
      end
      default: ;
    endcase
    // start low outside IDLE covers both the normal DONE exit and an abort
    if (state_q != S_IDLE && !start) begin
      state_d  = S_IDLE;
      req_rx_d = 1'b0;
      last_we  = 1'b0;
      tx_abort = 1'b1;
    end
    if (state_d == S_IDLE) begin
      addr_d = '0;
      din_d  = '0;
      data_d = '0;
      lat_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      start_q  <= 1'b0;
      wr_q     <= 1'b0;
      ch_q     <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      lat_q    <= '0;
      req_rx_q <= 1'b0;
      for (int unsigned k = 0; k < NCH; k++) last_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      start_q  <= start;
      wr_q     <= wr_d;
      ch_q     <= ch_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      lat_q    <= lat_d;
      req_rx_q <= req_rx_d;
      if (last_we) last_q[ch_q] <= addr_inc;
    end
  end

  always_comb begin
    we = '0;
    if (state_q == S_WR) we[ch_q] = start;
  end

  dcp_tx_seq u_tx_seq (
    .clk       (clk),
    .rstn      (rstn),
    .abort_i   (tx_abort),
    .go_i      (tx_go),
    .item_i    (tx_item),
    .ack_tx_i  (ack_tx),
    .done_o    (tx_done),
    .req_tx_o  (req_tx),
    .type_tx_o (type_tx),
    .dout_tx_o (dout_tx)
  );

  assign finish  = (state_q == S_DONE);
  assign req_rx  = req_rx_q;
  assign type_rx = req_rx_q;
  assign addr    = addr_q;
  assign din     = din_q;

endmodule

// File: tb/tb_dcp_mem_ctrl.sv
// Directed bench for dcp_mem_ctrl (NCH=2, AW=8, DW=32, DUMP_LEN=8, RD_LAT=2)
// with SCAN/PRINT responders and a two-channel memory model.
module tb_dcp_mem_ctrl;

  logic        clk, rstn, start, wr_mode;
  logic [0:0]  ch_sel;
  logic        finish, req_rx, type_rx, ack_rx, flag_rx;
  logic [31:0] din_rx;
  logic        req_tx, type_tx, ack_tx;
  logic [31:0] dout_tx;
  logic [7:0]  addr;
  logic [31:0] din;
  logic [1:0]  we;
  logic [63:0] dout_mem;

  dcp_mem_ctrl #(.NCH(2), .AW(8), .DW(32), .DUMP_LEN(8), .RD_LAT(2)) dut (
    .clk(clk), .rstn(rstn), .start(start), .wr_mode(wr_mode), .ch_sel(ch_sel),
    .finish(finish), .req_rx(req_rx), .type_rx(type_rx), .ack_rx(ack_rx),
    .flag_rx(flag_rx), .din_rx(din_rx), .req_tx(req_tx), .type_tx(type_tx),
    .ack_tx(ack_tx), .dout_tx(dout_tx), .addr(addr), .din(din), .we(we),
    .dout_mem(dout_mem)
  );

`ifdef DCP_MEM_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif

  typedef struct packed { logic flag; logic [31:0] d; } rx_t;
  typedef struct packed { logic ty; logic [31:0] d; } pr_t;
  typedef struct {
    bit        wr;
    bit [0:0]  ch;
    bit        aflag;
    bit [31:0] a;
    bit        dflag;
    bit [31:0] d;
    bit [7:0]  exp_start;
    int        exp_n;
    bit        exp_q;
    bit [1:0]  exp_we;
    bit [7:0]  exp_wa;
    bit [31:0] exp_wd;
  } vec_t;

  int tests = 0, fails = 0;
  int tx_delay = 0, tx_wait = 0, tx_unstable = 0, both_hi = 0;
  logic        cap_ty;
  logic [31:0] cap_d;
  rx_t rxq[$];
  pr_t prlog[$];
  bit strict = 1'b0;

  logic [31:0] mem [2][256];
  logic [31:0] ref_mem [2][256];
  logic [31:0] st1 [2];
  logic [31:0] st2 [2];
  logic [7:0]  prev_q;
  int          since_q, since_now;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int k, int a);
    if (k == 0) return 32'h1000_0000 + 32'(a) * 32'h0001_0001;
    return 32'hC0DE_0000 ^ (32'(a) << 8) ^ 32'(a);
  endfunction

  // memory: 2-stage read pipeline, or (strict) data valid only RD_LAT cycles after addr change
  always_comb since_now = (addr == prev_q) ? since_q + 1 : 0;
  always_comb begin
    for (int k = 0; k < 2; k++)
      dout_mem[k*32 +: 32] = strict ? ((since_now == 2) ? mem[k][addr] : 32'hBAAD_F00D) : st2[k];
  end
  always @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < 2; k++) begin
        for (int a = 0; a < 256; a++) mem[k][a] <= init_word(k, a);
        st1[k] <= '0;
        st2[k] <= '0;
      end
      prev_q  <= '0;
      since_q <= 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (we[k]) mem[k][addr] <= din;
        st1[k] <= mem[k][addr];
        st2[k] <= st1[k];
      end
      prev_q  <= addr;
      since_q <= since_now;
    end
  end

  initial begin
    rx_t it;
    ack_rx = 1'b0; flag_rx = 1'b0; din_rx = '0;
    forever begin
      @(negedge clk);
      if (ack_rx) ack_rx = 1'b0;
      else if (req_rx && rxq.size() > 0) begin
        it = rxq.pop_front();
        din_rx = it.d; flag_rx = it.flag; ack_rx = 1'b1;
      end
    end
  end

  initial begin
    ack_tx = 1'b0;
    forever begin
      @(negedge clk);
      if (req_rx && req_tx) both_hi++;
      if (ack_tx) ack_tx = 1'b0;
      else if (req_tx) begin
        if (tx_wait == 0) begin cap_ty = type_tx; cap_d = dout_tx; end
        else if (type_tx !== cap_ty || dout_tx !== cap_d) tx_unstable++;
        if (tx_wait >= tx_delay) begin
          prlog.push_back({type_tx, dout_tx});
          ack_tx = 1'b1; tx_wait = 0;
        end else tx_wait++;
      end else tx_wait = 0;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(bit wr, bit [0:0] ch, bit aflag, bit [31:0] a, bit dflag,
                              bit [31:0] d, bit [7:0] es, int en, bit eq, bit [1:0] ew,
                              bit [7:0] ewa, bit [31:0] ewd);
    vec_t v;
    v.wr = wr; v.ch = ch; v.aflag = aflag; v.a = a; v.dflag = dflag; v.d = d;
    v.exp_start = es; v.exp_n = en; v.exp_q = eq; v.exp_we = ew; v.exp_wa = ewa; v.exp_wd = ewd;
    return v;
  endfunction

  task automatic do_vec(input vec_t v, input string nm, input int budget);
    pr_t        expq[$];
    int         we_cyc = 0;
    logic [1:0] we_or = '0;
    logic [7:0] w_a = '0, a8;
    logic [31:0] w_d = '0;
    logic       got = 1'b0;
    rxq.delete(); prlog.delete();
    rxq.push_back({v.aflag, v.a});
    if (v.wr && !v.aflag) rxq.push_back({v.dflag, v.d});
    wr_mode = v.wr; ch_sel = v.ch; start = 1'b1;
    for (int c = 0; c < budget && !got; c++) begin
      @(negedge clk);
      if (we != 2'b00) begin we_cyc++; we_or |= we; w_a = addr; w_d = din; end
      got = finish;
    end
    chk({nm, " finish"}, 64'(got), 64'd1);
    chk({nm, " we_cycles"}, 64'(we_cyc), (v.exp_we != 0) ? 64'd1 : 64'd0);
    chk({nm, " we_value"}, 64'(we_or), 64'(v.exp_we));
    if (v.exp_we != 0) begin
      chk({nm, " wr_addr"}, 64'(w_a), 64'(v.exp_wa));
      chk({nm, " wr_data"}, 64'(w_d), 64'(v.exp_wd));
      ref_mem[v.ch][v.exp_wa] = v.exp_wd;
    end
    if (v.exp_q) expq.push_back({1'b0, 32'h3F});
    for (int i = 0; i < v.exp_n; i++) begin
      a8 = v.exp_start + 8'(i);
      expq.push_back({1'b1, 24'h0, a8});
      expq.push_back({1'b0, 32'h3A});
      expq.push_back({1'b1, ref_mem[v.ch][a8]});
      expq.push_back({1'b0, 32'h0A});
    end
    chk({nm, " print_count"}, 64'(prlog.size()), 64'(expq.size()));
    for (int i = 0; i < expq.size(); i++)
      chk($sformatf("%s print[%0d]", nm, i), (i < prlog.size()) ? 64'(prlog[i]) : 64'hFFFF_FFFF_FFFF, 64'(expq[i]));
    start = 1'b0;
    @(negedge clk);
    chk({nm, " idle_after"}, 64'({finish, req_rx, req_tx, we, addr}), 64'd0);
    @(negedge clk);
  endtask

  vec_t vt[9];

  initial begin
    logic got;
    rstn = 1'b0; start = 1'b0; wr_mode = 1'b0; ch_sel = '0;
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 256; a++) ref_mem[k][a] = init_word(k, a);

    vt[0] = mk(0, 0, 0, 32'h10,  0, 0, 8'h10, 8, 0, 2'b00, 8'h00, 32'h0);
    vt[1] = mk(0, 0, 1, 32'h0,   0, 0, 8'h18, 8, 0, 2'b00, 8'h00, 32'h0);
    vt[2] = mk(0, 0, 0, 32'h1FC, 0, 0, 8'hFC, 8, 0, 2'b00, 8'h00, 32'h0);
    vt[3] = mk(0, 0, 1, 32'h0,   0, 0, 8'h04, 8, 0, 2'b00, 8'h00, 32'h0);
    vt[4] = mk(1, 1, 0, 32'h20,  0, 32'hDEADBEEF, 8'h20, RB, 0, 2'b10, 8'h20, 32'hDEADBEEF);
    vt[5] = mk(0, 1, 0, 32'h1E,  0, 0, 8'h1E, 8, 0, 2'b00, 8'h00, 32'h0);
    vt[6] = mk(1, 0, 1, 32'h0,   0, 0, 8'h00, 0, 1, 2'b00, 8'h00, 32'h0);
    vt[7] = mk(1, 0, 0, 32'h30,  1, 0, 8'h00, 0, 1, 2'b00, 8'h00, 32'h0);
    vt[8] = mk(0, 1, 1, 32'h0,   0, 0, 8'h26, 8, 0, 2'b00, 8'h00, 32'h0);

    repeat (3) @(negedge clk);
    chk("reset ctl", 64'({finish, req_rx, type_rx, req_tx, type_tx, we, addr}), 64'd0);
    chk("reset data", 64'({din, dout_tx}), 64'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 9; i++) do_vec(vt[i], $sformatf("vec%0d", i), 3000);

    // abort while the data word of the first line is being printed
    tx_delay = 20;
    rxq.delete(); prlog.delete();
    rxq.push_back({1'b0, 32'h40});
    wr_mode = 1'b0; ch_sel = 1'b0; start = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 2000 && !got; c++) begin
      @(negedge clk);
      got = req_tx && type_tx && (prlog.size() == 2);
    end
    chk("abort reach_pr_d", 64'(got), 64'd1);
    chk("abort pr_d_data", 64'(dout_tx), 64'(ref_mem[0][8'h40]));
    start = 1'b0;
    @(negedge clk);
    chk("abort outputs", 64'({finish, req_rx, type_rx, req_tx, type_tx, we, addr}), 64'd0);
    chk("abort data", 64'({din, dout_tx}), 64'd0);
    repeat (3) @(negedge clk);
    tx_delay = 0;
    do_vec(mk(0, 0, 1, 32'h0, 0, 0, 8'h0C, 8, 0, 2'b00, 8'h00, 32'h0), "after_abort", 3000);

    // strict read-latency window plus 50-cycle PRINT ack delay
    strict = 1'b1; tx_delay = 50; tx_unstable = 0;
    do_vec(mk(0, 1, 0, 32'h80, 0, 0, 8'h80, 8, 0, 2'b00, 8'h00, 32'h0), "lat2_slow", 6000);
    chk("lat2_slow tx_stable", 64'(tx_unstable), 64'd0);
    strict = 1'b0; tx_delay = 0;

    chk("single_req", 64'(both_hi), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
